cv32e40p_mult_ft_ctrl: RTL

CV32E40P_MULT_FT_CTRL -- requirements
Module: cv32e40p_mult_ft_ctrl

---
 rtl/cv32e40p_mult_ft_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/cv32e40p_mult_ft_ctrl.sv
// cv32e40p_mult_ft_ctrl: retry controller around a TMR multiplier that re-executes operations flagged by the voters
// Ports: req_* accept an operation, mult_* drive and observe the TMR multiplier, rsp_* return result/error/retries,
// err_count_o/fatal_o report fault status (cleared by clear_i); clk rising edge, rst asynchronous active-high.
package cv32e40p_mult_ft_pkg;
  typedef enum logic [2:0] {
    MUL_MAC32 = 3'b000,
    MUL_MSU32 = 3'b001,
    MUL_I     = 3'b010,
    MUL_IR    = 3'b011,
    MUL_DOT8  = 3'b100,
    MUL_DOT16 = 3'b101,
    MUL_H     = 3'b110
  } mul_opcode_e;
endpackage

module cv32e40p_mult_ft_ctrl
  import cv32e40p_mult_ft_pkg::*;
#(
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  mul_opcode_e       req_operator_i,
  input  logic [31:0]       req_op_a_i,
  input  logic [31:0]       req_op_b_i,
  input  logic [31:0]       req_op_c_i,
  output logic              mult_enable_o,
  output mul_opcode_e       mult_operator_o,
  output logic [31:0]       mult_op_a_o,
  output logic [31:0]       mult_op_b_o,
  output logic [31:0]       mult_op_c_o,
  output logic              mult_ex_ready_o,
  input  logic              mult_ready_i,
  input  logic [31:0]       mult_result_i,
  input  logic [3:0]        error_detected_mult_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_result_o,
  output logic              rsp_error_o,
  output logic [1:0]        rsp_retries_o,
  output logic [CNT_W-1:0]  err_count_o,
  output logic              fatal_o,
  input  logic              clear_i
);
  typedef enum logic [1:0] {IDLE, EXEC, RETRY, RESP} state_e;
  state_e      state;
  logic [1:0]  retry_cnt;
  logic        error_seen;
  logic [31:0] result;
  logic        rsp_err;
  logic        flag, err, done, inc, last;
  assign flag = |error_detected_mult_i;
  assign err  = error_seen | flag;
  assign done = (state == EXEC) & mult_ready_i;
  assign inc  = done & err;
  assign last = retry_cnt >= 2'(MAX_RETRY);
  // req_ready is gated by rst so every output reads zero while reset is held
  assign req_ready_o     = (state == IDLE) & ~rst;
  assign mult_enable_o   = state == EXEC;
  assign mult_ex_ready_o = state == EXEC;
  assign rsp_valid_o     = state == RESP;
  assign rsp_result_o    = rsp_valid_o ? result : '0;
  assign rsp_error_o     = rsp_valid_o & rsp_err;
  assign rsp_retries_o   = rsp_valid_o ? retry_cnt : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      mult_operator_o <= MUL_MAC32;
      mult_op_a_o     <= '0;
      mult_op_b_o     <= '0;
      mult_op_c_o     <= '0;
      retry_cnt       <= '0;
      error_seen      <= 1'b0;
      result          <= '0;
      rsp_err         <= 1'b0;
      err_count_o     <= '0;
      fatal_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          mult_operator_o <= req_operator_i;
          mult_op_a_o     <= req_op_a_i;
          mult_op_b_o     <= req_op_b_i;
          mult_op_c_o     <= req_op_c_i;
          retry_cnt       <= '0;
          error_seen      <= 1'b0;
          state           <= EXEC;
        end
        EXEC: begin
          error_seen <= err;
          if (mult_ready_i) begin
            result  <= mult_result_i;
            rsp_err <= err & last;
            state   <= (err & ~last) ? RETRY : RESP;
            if (err & ~last) retry_cnt <= retry_cnt + 2'd1;
          end
        end
        RETRY: begin
          error_seen <= 1'b0;
          state      <= EXEC;
        end
        RESP: if (rsp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
      err_count_o <= clear_i ? '0 : err_count_o + CNT_W'(inc & ~&err_count_o);
      fatal_o     <= ~clear_i & (fatal_o | (inc & last));
    end
  end
endmodule
